load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : RV32I load/store unit. Aligns/replicates stores, extends
//               loads, and drives a req/gnt/rvalid bus with a timeout abort.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        core_valid,
   input  logic        core_we,
   input  logic [2:0]  core_funct3,
   input  logic [31:0] core_addr,
   input  logic [31:0] core_wdata,
   output logic        core_done,
   output logic        core_err,
   output logic [31:0] core_rdata,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int              c_CW  = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [c_CW-1:0] c_TMO = c_CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_we;
   logic [2:0]      r_f3;
   logic [1:0]      r_lane;
   logic [c_CW-1:0] r_cnt;
   logic            r_done;
   logic            r_err;
   logic [31:0]     r_rdata;
   logic            r_req;
   logic            r_bus_we;
   logic [31:0]     r_bus_addr;
   logic [3:0]      r_bus_be;
   logic [31:0]     r_bus_wdata;

   logic [1:0]      w_size;
   logic            w_illegal;
   logic            w_misaligned;
   logic [3:0]      w_be;
   logic [31:0]     w_wdata;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [31:0]     w_ext;
   logic [c_CW-1:0] w_cnt_nxt;
   logic            w_tmo;

   assign w_size       = core_funct3[1:0];
   assign w_illegal    = core_we ? (core_funct3 > 3'd2)
                                 : (core_funct3 == 3'b011 || core_funct3[2:1] == 2'b11);
   assign w_misaligned = (w_size == 2'b01 && core_addr[0]) ||
                         (w_size == 2'b10 && core_addr[1:0] != 2'b00);

   // Stores replicate data into every lane so the byte enables alone pick the target.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = '0;
      if (core_we) begin
         w_wdata = core_wdata;
         case (w_size)
            2'b00: begin
               w_be    = 4'b0001 << core_addr[1:0];
               w_wdata = {4{core_wdata[7:0]}};
            end
            2'b01: begin
               w_be    = core_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{core_wdata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   assign w_byte = bus_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = r_lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      case (r_f3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'h000000, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'h0000, w_half};
         default: w_ext = bus_rdata;
      endcase
   end

   assign w_cnt_nxt = r_cnt + 1'b1;
   assign w_tmo     = (w_cnt_nxt == c_TMO);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_we        <= 1'b0;
         r_f3        <= 3'b000;
         r_lane      <= 2'b00;
         r_cnt       <= '0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
         r_rdata     <= '0;
         r_req       <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
      end else begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (core_valid) begin
                  r_we   <= core_we;
                  r_f3   <= core_funct3;
                  r_lane <= core_addr[1:0];
                  if (w_illegal || w_misaligned) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                     r_err   <= 1'b1;
                  end else begin
                     r_state     <= S_REQ;
                     r_cnt       <= '0;
                     r_req       <= 1'b1;
                     r_bus_we    <= core_we;
                     r_bus_addr  <= {core_addr[31:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata;
                  end
               end
            end
            S_REQ: begin
               r_cnt <= w_cnt_nxt;
               // A granted store completes even on the last allowed cycle.
               if ((bus_gnt && r_we) || w_tmo || bus_gnt) begin
                  r_req       <= 1'b0;
                  r_bus_we    <= 1'b0;
                  r_bus_be    <= '0;
                  r_bus_wdata <= '0;
               end
               if (bus_gnt && r_we) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
               end else if (w_tmo) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end else if (bus_gnt) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= w_cnt_nxt;
               if (bus_rvalid) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_rdata <= w_ext;
               end else if (w_tmo) begin
                  r_state <= S_DONE;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_rdata <= '0;
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign core_done  = r_done;
   assign core_err   = r_err;
   assign core_rdata = r_rdata;
   assign bus_req    = r_req;
   assign bus_we     = r_bus_we;
   assign bus_addr   = r_bus_addr;
   assign bus_be     = r_bus_be;
   assign bus_wdata  = r_bus_wdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Randomized and directed bench for load_store_unit against a
//               cycle-budget reference model of the access rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

   localparam int c_TMO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_valid;
   logic        core_we;
   logic [2:0]  core_funct3;
   logic [31:0] core_addr;
   logic [31:0] core_wdata;
   logic        core_done;
   logic        core_err;
   logic [31:0] core_rdata;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic        bus_gnt;
   logic        bus_rvalid;
   logic [31:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   load_store_unit #(.TIMEOUT(c_TMO)) dut (
      .clk         (clk),
      .reset       (reset),
      .core_valid  (core_valid),
      .core_we     (core_we),
      .core_funct3 (core_funct3),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_done   (core_done),
      .core_err    (core_err),
      .core_rdata  (core_rdata),
      .bus_req     (bus_req),
      .bus_we      (bus_we),
      .bus_addr    (bus_addr),
      .bus_be      (bus_be),
      .bus_wdata   (bus_wdata),
      .bus_gnt     (bus_gnt),
      .bus_rvalid  (bus_rvalid),
      .bus_rdata   (bus_rdata)
   );

   always #5 clk = ~clk;

   function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
      bit ok;
      if (we) ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
      else    ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      if (ok && f3[1:0] == 2'd1 && a[0])         ok = 1'b0;
      if (ok && f3[1:0] == 2'd2 && a[1:0] != 0)  ok = 1'b0;
      return ok;
   endfunction

   function automatic logic [3:0] exp_be(input bit we, input logic [2:0] f3, input logic [31:0] a);
      logic [3:0] one = 4'd1;
      if (!we)            return 4'hF;
      if (f3[1:0] == 2'd0) return one << a[1:0];
      if (f3[1:0] == 2'd1) return a[1] ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
      if (f3[1:0] == 2'd0) return (wd & 32'hFF) * 32'h0101_0101;
      if (f3[1:0] == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
      return wd;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] word);
      logic [31:0] b = (word >> (8 * a[1:0])) & 32'hFF;
      logic [31:0] h = (word >> (16 * a[1])) & 32'hFFFF;
      case (f3)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd4:    return b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd5:    return h;
         default: return word;
      endcase
   endfunction

   // g: REQ cycles before grant (99 = never); r: WAIT cycles before rvalid (99 = never).
   task automatic do_access(input bit we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] word,
                            input int g, input int r, input string name);
      bit          legal   = is_legal(we, f3, a);
      int          total   = legal ? (g + 1 + (we ? 0 : r)) : 0;
      bit          tmo     = legal && (total > c_TMO);
      int          exp_lat = 1 + (tmo ? c_TMO : total);
      bit          exp_err = !legal || tmo;
      logic [31:0] exp_rd  = tmo ? 32'h0 : exp_load(f3, a, word);
      logic [31:0] rd_seen = 32'h0;
      int          n = 0, reqc = 0, waitc = 0;
      bit          gnt_given = 0, done_seen = 0;

      @(negedge clk);
      core_valid = 1'b1; core_we = we; core_funct3 = f3; core_addr = a; core_wdata = wd;
      while (!done_seen && n < 40) begin
         @(negedge clk);
         n++;
         bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = $urandom;
         if (core_done) begin
            done_seen = 1;
            rd_seen   = core_rdata;
            checks++;
            if (n !== exp_lat) begin
               errors++; $display("FAIL %s latency: got %0d want %0d", name, n, exp_lat);
            end
            checks++;
            if (core_err !== exp_err) begin
               errors++; $display("FAIL %s err: got %b want %b", name, core_err, exp_err);
            end
            checks++;
            if (bus_req !== 1'b0 || (!legal && reqc != 0)) begin
               errors++; $display("FAIL %s req: req=%b reqc=%0d want no req", name, bus_req, reqc);
            end
            if (legal && (!we || tmo)) begin
               checks++;
               if (core_rdata !== exp_rd) begin
                  errors++; $display("FAIL %s rdata: got %h want %h", name, core_rdata, exp_rd);
               end
            end
            core_valid = 1'b0;
         end else if (bus_req) begin
            reqc++;
            checks++;
            if (bus_addr !== (a & 32'hFFFF_FFFC) || bus_we !== we || bus_be !== exp_be(we, f3, a)) begin
               errors++;
               $display("FAIL %s bus: addr=%h we=%b be=%b want addr=%h we=%b be=%b", name,
                        bus_addr, bus_we, bus_be, a & 32'hFFFF_FFFC, we, exp_be(we, f3, a));
            end
            if (we) begin
               checks++;
               if (bus_wdata !== exp_wdata(f3, wd)) begin
                  errors++; $display("FAIL %s wdata: got %h want %h", name, bus_wdata, exp_wdata(f3, wd));
               end
            end
            if (reqc == g + 1) begin
               bus_gnt = 1'b1; gnt_given = 1;
            end else begin
               bus_rvalid = 1'($urandom % 2);
            end
         end else begin
            checks++;
            if (bus_we !== 1'b0 || bus_be !== 4'h0 || bus_wdata !== 32'h0) begin
               errors++; $display("FAIL %s idle bus: we=%b be=%b wdata=%h want zeros", name, bus_we, bus_be, bus_wdata);
            end
            if (gnt_given) begin
               waitc++;
               if (waitc == r) begin
                  bus_rvalid = 1'b1; bus_rdata = word;
               end
            end
         end
      end
      bus_gnt = 1'b0; bus_rvalid = 1'b0;
      if (!done_seen) begin
         checks++; errors++;
         core_valid = 1'b0;
         $display("FAIL %s done: got none want pulse within 40 cycles", name);
      end
      @(negedge clk);
      checks++;
      if (core_done !== 1'b0 || core_err !== 1'b0 || core_rdata !== rd_seen) begin
         errors++;
         $display("FAIL %s after done: done=%b err=%b rdata=%h want 0 0 %h", name,
                  core_done, core_err, core_rdata, rd_seen);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; core_valid = 1'b0; core_we = 1'b0; core_funct3 = 3'd0;
      core_addr = '0; core_wdata = '0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({core_done, core_err, core_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata} !== '0) begin
         errors++;
         $display("FAIL reset: done=%b err=%b rdata=%h req=%b we=%b addr=%h be=%b wdata=%h want all 0",
                  core_done, core_err, core_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata);
      end
      reset = 1'b1;
   endtask

   task automatic test_store_byte();
      do_access(1'b1, 3'b000, 32'h103, 32'hAB, 32'h0, 1, 1, "sb_0x103");
      do_access(1'b1, 3'b001, 32'h102, 32'h1234_BEEF, 32'h0, 0, 1, "sh_0x102");
   endtask

   task automatic test_load_extend();
      do_access(1'b0, 3'b000, 32'h62, 32'h0, 32'h0080_FF00, 0, 2, "lb_0x62");
      do_access(1'b0, 3'b100, 32'h62, 32'h0, 32'h0080_FF00, 0, 2, "lbu_0x62");
      do_access(1'b0, 3'b001, 32'h62, 32'h0, 32'h0080_FF00, 0, 2, "lh_0x62");
      do_access(1'b0, 3'b001, 32'h60, 32'h0, 32'h0080_FF00, 0, 1, "lh_0x60");
   endtask

   task automatic test_misaligned();
      do_access(1'b0, 3'b010, 32'h66, 32'h0, 32'h0, 0, 1, "lw_0x66");
      do_access(1'b0, 3'b101, 32'h65, 32'h0, 32'h0, 0, 1, "lhu_0x65");
      do_access(1'b1, 3'b100, 32'h40, 32'h0, 32'h0, 0, 1, "illegal_store");
   endtask

   task automatic test_timeout();
      do_access(1'b0, 3'b010, 32'h80, 32'h0, 32'h1234_5678, 0, 99, "lw_no_rvalid");
      do_access(1'b1, 3'b010, 32'h84, 32'h5, 32'h0, 99, 1, "sw_no_gnt");
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      core_valid = 1'b1; core_we = 1'b0; core_funct3 = 3'b010; core_addr = 32'h60;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || core_done !== 1'b0) begin
         errors++; $display("FAIL reset_in_req: req=%b done=%b want 0 0", bus_req, core_done);
      end
      core_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      core_valid = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b1;
      @(negedge clk);
      bus_gnt = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if (bus_req !== 1'b0 || core_done !== 1'b0 || core_err !== 1'b0 || core_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_in_wait: req=%b done=%b err=%b rdata=%h want 0 0 0 0",
                  bus_req, core_done, core_err, core_rdata);
      end
      core_valid = 1'b0;
      @(negedge clk) reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus_rvalid = 1'b1;
         @(negedge clk);
         checks++;
         if (core_done !== 1'b0) begin
            errors++; $display("FAIL reset_no_done: got done=%b want 0", core_done);
         end
      end
      bus_rvalid = 1'b0;
      do_access(1'b1, 3'b010, 32'h64, 32'd25, 32'h0, 0, 1, "sw_after_reset");
   endtask

   task automatic test_back_to_back();
      int t1 = -1, t2 = -1;
      @(negedge clk);
      core_valid = 1'b1; core_we = 1'b1; core_funct3 = 3'b010;
      core_addr = 32'h40; core_wdata = 32'hAAAA_0001;
      for (int n = 1; n <= 30 && t2 < 0; n++) begin
         @(negedge clk);
         bus_gnt = bus_req;
         if (core_done) begin
            checks++;
            if (bus_req !== 1'b0) begin
               errors++; $display("FAIL b2b req_in_done: got %b want 0", bus_req);
            end
            if (t1 < 0) begin
               t1 = n; core_addr = 32'h44; core_wdata = 32'hBBBB_0002;
            end else begin
               t2 = n; core_valid = 1'b0;
            end
         end else if (t1 > 0 && n == t1 + 1) begin
            checks++;
            if (bus_req !== 1'b0) begin
               errors++; $display("FAIL b2b idle_gap: req=%b want 0", bus_req);
            end
         end else if (t1 > 0 && bus_req) begin
            checks++;
            if (bus_addr !== 32'h44 || bus_wdata !== 32'hBBBB_0002) begin
               errors++; $display("FAIL b2b second: addr=%h wdata=%h want 00000044 bbbb0002", bus_addr, bus_wdata);
            end
         end
      end
      bus_gnt = 1'b0;
      core_valid = 1'b0;
      checks++;
      if (t1 < 0 || t2 - t1 !== 3) begin
         errors++; $display("FAIL b2b spacing: got %0d want 3 (t1=%0d t2=%0d)", t2 - t1, t1, t2);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) begin
         bit          we   = 1'($urandom % 2);
         logic [2:0]  f3   = 3'($urandom % 8);
         logic [31:0] a    = $urandom;
         logic [31:0] wd   = $urandom;
         logic [31:0] word = $urandom;
         int          g    = $urandom_range(0, 3);
         int          r    = $urandom_range(1, 3);
         if (i % 2 == 0) a[1:0] = 2'b00;
         do_access(we, f3, a, wd, word, g, r, "random");
      end
   endtask

   initial begin
      test_reset();
      test_store_byte();
      test_load_extend();
      test_misaligned();
      test_timeout();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
